alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Registered, parametrised successor to the combinational ALU core. Same S/M/Cin op encoding.
//  Adds a 2-stage valid/ready pipeline and a flag register. Cin can come from the stored C flag,
//  so back-to-back ops chain into multi-word arithmetic. Also adds a sticky-overflow flag.
//  Sits between the operand-issue logic and the writeback path of the datapath.
// PARAMETERS
//  W        32   operand/result width, >=2
// PORTS
//  clk        in   1  single clock; all state updates on posedge
//  rst_n      in   1  synchronous, active-low reset
//  in_valid   in   1  request valid
//  in_ready   out  1  request accepted when in_valid&in_ready
//  opA        in   W  operand A
//  opB        in   W  operand B
//  S          in   4  function select
//  M          in   1  0=logic, 1=arithmetic
//  Cin        in   1  carry-in when cin_sel=0
//  cin_sel    in   1  1: carry-in = stored C flag (chaining)
//  flag_clr   in   1  clear flags_q and v_sticky
//  out_valid  out  1  result valid
//  out_ready  in   1  result consumed when out_valid&out_ready
//  DO         out  W  result
//  C,V,N,Z    out  1  flags of the result on DO
//  flags_q    out  4  {C,V,N,Z} of the most recently computed op
//  v_sticky   out  1  OR of V over all ops since reset/flag_clr
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): all outputs 0, in_ready=1 the cycle after; in-flight ops are dropped.
//  Pipeline: stage1 registers the request; stage2 computes and registers DO/flags.
//  - en2 = s1_valid & (~out_valid | out_ready)
//  - in_ready = ~s1_valid | en2 (combinational)
//  Latency 2 cycles from accept to out_valid. Throughput 1 op/cycle; out_ready=0 stalls both stages.
//  DO/C/V/N/Z are held stable while out_valid & ~out_ready.
//  M=0 logic ops: 0000 0 | 0001 ~(A|B) | 0010 ~A&B | 0011 ~A | 0100 A&~B | 0101 ~B | 0110 A^B
//   | 0111 ~(A&B) | 1000 A&B | 1001 ~(A^B) | 1010 B | 1011 ~A|B | 1100 A | 1101 A|~B | 1110 A|B
//   | 1111 all-ones. For logic ops C=0, V=0.
//  M=1 arithmetic, computed as a W+1-bit sum:
//   1001 A+B+ci | 0110 A+~B+ci | 1100 A+A+ci | 1111 A+{W{1}}+ci | other codes A+ci.
//   ci = cin_sel ? flags_q.C : Cin. The value of flags_q.C is sampled in the cycle the op enters stage 2.
//  Arithmetic flags:
//   - C = bit W of the sum (for subtraction, 1 = no borrow)
//   - V = signed overflow of the two addends
//   - N = DO[W-1]; Z = (DO==0)
//  flags_q loads {C,V,N,Z} on en2.
//  flag_clr without en2: flags_q<=0 and v_sticky<=0.
//  flag_clr with en2: flags_q takes the new flags; v_sticky<=V_new.
//  Otherwise v_sticky <= v_sticky | (en2&V_new).
// CONFIGURATION
//  ALU_SAT_EN defined: for M=1 with V=1, DO saturates. Result is 2^(W-1)-1 if the true result is
//  positive, -2^(W-1) if negative. C, V, N and Z still describe the raw, unsaturated sum.
//  ALU_SAT_EN undefined: DO is the wrapped sum; saturation logic is absent.
// STRUCTURE
//  alu_pkg holds:
//   - localparams for S codes (ALU_S_ADD=4'b1001, ALU_S_SUB=4'b0110, ...)
//   - flag bit indices FLG_C=3, FLG_V=2, FLG_N=1, FLG_Z=0
//  Sub-module alu_func_unit: combinational W-bit function and flag generator, instantiated in stage 2.
//  alu_pipe owns the handshake, the flag register and saturation.
// TESTING
//  1. Logic sweep, all 16 S codes, M=0, A=f05af05a, B=0fa5f05a, out_ready=1.
//     -> Results out 2 cycles after accept; e.g. S=0110 DO=ffff0000, C=V=0, N=1, Z=0.
//  2. Add: S=1001 M=1 Cin=0, A=01010000, B=10100101 -> DO=11110101, C=V=N=Z=0.
//     Sub: S=0110 M=1 Cin=1, A=0000ffff, B=00010000 -> DO=ffffffff, C=0, N=1.
//  3. Overflow: S=0110 M=1 Cin=1, A=80000000, B=00000001.
//     -> DO=7fffffff, C=1, V=1, v_sticky=1 from the next cycle.
//     -> With ALU_SAT_EN: DO=80000000 and the same flags.
//  4. Chain: S=1001 A=ffffffff B=00000001 Cin=0 -> DO=0, C=1, Z=1.
//     Next op: A=B=0, cin_sel=1 -> DO=00000001, C=0. Sent back-to-back with no gap.
//  5. Backpressure: hold out_ready=0 for 5 cycles with 3 ops offered.
//     -> Exactly 2 accepted; DO held stable; in_ready=0. On release, results drain in order.
//  6. Reset and clear:
//     - Drop rst_n with 2 ops in flight -> out_valid=0 and flags_q=0 next cycle; no stale result.
//     - Assert flag_clr together with en2 -> flags_q = new flags.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: function-select codes and flag bit positions.
package alu_pkg;

  // M=0 logic function codes
  localparam logic [3:0] ALU_S_ZERO      = 4'b0000;
  localparam logic [3:0] ALU_S_NOR       = 4'b0001;
  localparam logic [3:0] ALU_S_NOTA_ANDB = 4'b0010;
  localparam logic [3:0] ALU_S_NOTA      = 4'b0011;
  localparam logic [3:0] ALU_S_A_ANDNOTB = 4'b0100;
  localparam logic [3:0] ALU_S_NOTB      = 4'b0101;
  localparam logic [3:0] ALU_S_XOR       = 4'b0110;
  localparam logic [3:0] ALU_S_NAND      = 4'b0111;
  localparam logic [3:0] ALU_S_AND       = 4'b1000;
  localparam logic [3:0] ALU_S_XNOR      = 4'b1001;
  localparam logic [3:0] ALU_S_B         = 4'b1010;
  localparam logic [3:0] ALU_S_NOTA_ORB  = 4'b1011;
  localparam logic [3:0] ALU_S_A         = 4'b1100;
  localparam logic [3:0] ALU_S_A_ORNOTB  = 4'b1101;
  localparam logic [3:0] ALU_S_OR        = 4'b1110;
  localparam logic [3:0] ALU_S_ONES      = 4'b1111;

  // M=1 arithmetic function codes; any other code gives A+ci
  localparam logic [3:0] ALU_S_ADD = 4'b1001;
  localparam logic [3:0] ALU_S_SUB = 4'b0110;
  localparam logic [3:0] ALU_S_DBL = 4'b1100;
  localparam logic [3:0] ALU_S_DEC = 4'b1111;

  // bit positions inside the packed {C,V,N,Z} flag vector
  localparam int FLG_C = 3;
  localparam int FLG_V = 2;
  localparam int FLG_N = 1;
  localparam int FLG_Z = 0;

endpackage

// File: rtl/alu_func_unit.sv
// Combinational W-bit ALU function and flag generator used by stage 2 of alu_pipe.
// Flags always describe the raw (unsaturated) result.
module alu_func_unit
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   s,
  input  logic         m,
  input  logic         ci,
  output logic [W-1:0] res,
  output logic         c,
  output logic         v,
  output logic         n,
  output logic         z
);

  logic [W-1:0] lres;
  logic [W-1:0] addend;
  logic [W:0]   sum;

  always_comb begin
    lres = '0;
    case (s)
      ALU_S_ZERO:      lres = '0;
      ALU_S_NOR:       lres = ~(a | b);
      ALU_S_NOTA_ANDB: lres = ~a & b;
      ALU_S_NOTA:      lres = ~a;
      ALU_S_A_ANDNOTB: lres = a & ~b;
      ALU_S_NOTB:      lres = ~b;
      ALU_S_XOR:       lres = a ^ b;
      ALU_S_NAND:      lres = ~(a & b);
      ALU_S_AND:       lres = a & b;
      ALU_S_XNOR:      lres = ~(a ^ b);
      ALU_S_B:         lres = b;
      ALU_S_NOTA_ORB:  lres = ~a | b;
      ALU_S_A:         lres = a;
      ALU_S_A_ORNOTB:  lres = a | ~b;
      ALU_S_OR:        lres = a | b;
      ALU_S_ONES:      lres = '1;
    endcase
  end

  always_comb begin
    addend = '0;
    case (s)
      ALU_S_ADD: addend = b;
      ALU_S_SUB: addend = ~b;
      ALU_S_DBL: addend = a;
      ALU_S_DEC: addend = '1;
      default:   addend = '0;
    endcase
  end

  assign sum = {1'b0, a} + {1'b0, addend} + {{W{1'b0}}, ci};

  always_comb begin
    if (m) begin
      res = sum[W-1:0];
      c   = sum[W];
      // overflow: both addends share a sign that the sum does not
      v   = (a[W-1] == addend[W-1]) & (sum[W-1] != a[W-1]);
    end else begin
      res = lres;
      c   = 1'b0;
      v   = 1'b0;
    end
    n = res[W-1];
    z = ~|res;
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU with flag register, carry chaining and sticky overflow.
// Optional build macro ALU_SAT_EN: saturate DO on signed overflow of arithmetic ops.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] opA,
  input  logic [W-1:0] opB,
  input  logic [3:0]   S,
  input  logic         M,
  input  logic         Cin,
  input  logic         cin_sel,
  input  logic         flag_clr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] DO,
  output logic         C,
  output logic         V,
  output logic         N,
  output logic         Z,
  output logic [3:0]   flags_q,
  output logic         v_sticky
);

  logic         s1_valid;
  logic [W-1:0] s1_a;
  logic [W-1:0] s1_b;
  logic [3:0]   s1_s;
  logic         s1_m;
  logic         s1_cin;
  logic         s1_cin_sel;

  logic         en1;
  logic         en2;
  logic         ci;
  logic [W-1:0] fu_res;
  logic         fu_c, fu_v, fu_n, fu_z;
  logic [W-1:0] do_next;

  assign en2      = s1_valid & (~out_valid | out_ready);
  assign in_ready = ~s1_valid | en2;
  assign en1      = in_valid & in_ready;

  // chained carry is taken from the flag register as the op moves into stage 2
  assign ci = s1_cin_sel ? flags_q[FLG_C] : s1_cin;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_s       <= '0;
      s1_m       <= 1'b0;
      s1_cin     <= 1'b0;
      s1_cin_sel <= 1'b0;
    end else if (en1) begin
      s1_valid   <= 1'b1;
      s1_a       <= opA;
      s1_b       <= opB;
      s1_s       <= S;
      s1_m       <= M;
      s1_cin     <= Cin;
      s1_cin_sel <= cin_sel;
    end else if (en2) begin
      s1_valid   <= 1'b0;
    end
  end

  alu_func_unit #(.W(W)) u_func (
    .a   (s1_a),
    .b   (s1_b),
    .s   (s1_s),
    .m   (s1_m),
    .ci  (ci),
    .res (fu_res),
    .c   (fu_c),
    .v   (fu_v),
    .n   (fu_n),
    .z   (fu_z)
  );

`ifdef ALU_SAT_EN
  // on overflow the raw sign is inverted from the true sign
  always_comb begin
    do_next = fu_res;
    if (s1_m && fu_v)
      do_next = fu_n ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
  end
`else
  assign do_next = fu_res;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      DO        <= '0;
      C         <= 1'b0;
      V         <= 1'b0;
      N         <= 1'b0;
      Z         <= 1'b0;
      flags_q   <= '0;
      v_sticky  <= 1'b0;
    end else begin
      if (en2) begin
        out_valid <= 1'b1;
        DO        <= do_next;
        C         <= fu_c;
        V         <= fu_v;
        N         <= fu_n;
        Z         <= fu_z;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (en2) begin
        flags_q[FLG_C] <= fu_c;
        flags_q[FLG_V] <= fu_v;
        flags_q[FLG_N] <= fu_n;
        flags_q[FLG_Z] <= fu_z;
      end else if (flag_clr) begin
        flags_q <= '0;
      end

      if (flag_clr)
        v_sticky <= en2 & fu_v;
      else
        v_sticky <= v_sticky | (en2 & fu_v);
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed scenarios plus randomized traffic scored
// against an integer-arithmetic reference model and an in-order expectation queue.
module tb_alu_pipe;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] opA = '0;
  logic [W-1:0] opB = '0;
  logic [3:0]   S = '0;
  logic         M = 1'b0;
  logic         Cin = 1'b0;
  logic         cin_sel = 1'b0;
  logic         flag_clr = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] DO;
  logic         C, V, N, Z;
  logic [3:0]   flags_q;
  logic         v_sticky;

  always #5 clk = ~clk;

  alu_pipe #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opA(opA), .opB(opB), .S(S), .M(M), .Cin(Cin), .cin_sel(cin_sel),
    .flag_clr(flag_clr), .out_valid(out_valid), .out_ready(out_ready),
    .DO(DO), .C(C), .V(V), .N(N), .Z(Z), .flags_q(flags_q), .v_sticky(v_sticky)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [W-1:0] d;
    logic [3:0]   f;
  } exp_t;

  exp_t         expq[$];
  logic         model_c = 1'b0;
  logic         model_sticky = 1'b0;
  logic [W-1:0] last_do = '0, prev_do = '0;
  logic [3:0]   last_f = '0, prev_f = '0;

  function automatic exp_t ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [3:0] s, input logic m, input logic ci);
    exp_t         e;
    logic [W-1:0] y;
    logic [63:0]  us;
    longint       tr, smax, smin;
    logic         ov;
    smax = (longint'(1) <<< (W-1)) - 1;
    smin = -(longint'(1) <<< (W-1));
    if (!m) begin
      case (s)
        4'd0:  e.d = '0;
        4'd1:  e.d = ~(a | b);
        4'd2:  e.d = ~a & b;
        4'd3:  e.d = ~a;
        4'd4:  e.d = a & ~b;
        4'd5:  e.d = ~b;
        4'd6:  e.d = a ^ b;
        4'd7:  e.d = ~(a & b);
        4'd8:  e.d = a & b;
        4'd9:  e.d = ~(a ^ b);
        4'd10: e.d = b;
        4'd11: e.d = ~a | b;
        4'd12: e.d = a;
        4'd13: e.d = a | ~b;
        4'd14: e.d = a | b;
        default: e.d = '1;
      endcase
      e.f = {1'b0, 1'b0, e.d[W-1], e.d == '0};
    end else begin
      case (s)
        4'b1001: y = b;
        4'b0110: y = ~b;
        4'b1100: y = a;
        4'b1111: y = '1;
        default: y = '0;
      endcase
      us = 64'(a) + 64'(y) + 64'(ci);
      tr = longint'($signed(a)) + longint'($signed(y)) + longint'(ci);
      ov = (tr > smax) || (tr < smin);
      e.d = us[W-1:0];
      e.f = {us[W], ov, us[W-1], us[W-1:0] == '0};
`ifdef ALU_SAT_EN
      if (ov) e.d = (tr > 0) ? smax[W-1:0] : smin[W-1:0];
`endif
    end
    return e;
  endfunction

  // scoreboard: observes both handshakes mid-cycle, away from the active edge
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      expq.delete();
      model_c = 1'b0;
      model_sticky = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          check("spurious_out", out_valid, 0);
        end else begin
          e = expq.pop_front();
          check("do", DO, e.d);
          check("flags", {C, V, N, Z}, e.f);
          check("flags_q", flags_q, e.f);
          model_sticky = model_sticky | e.f[2];
          check("v_sticky", v_sticky, model_sticky);
          prev_do = last_do; prev_f = last_f;
          last_do = DO;      last_f = {C, V, N, Z};
        end
      end
      if (in_valid && in_ready) begin
        e = ref_alu(opA, opB, S, M, cin_sel ? model_c : Cin);
        model_c = e.f[3];
        expq.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                      input logic m, input logic cin, input logic csel);
    logic acc;
    opA = a; opB = b; S = s; M = m; Cin = cin; cin_sel = csel; in_valid = 1'b1;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      if (acc) break;
      if (t == 59) check("send_timeout", 0, 1);
    end
    in_valid = 1'b0;
    cin_sel = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int t = 0; t < 60; t++) begin
      if (expq.size() == 0) break;
      tick();
    end
    check("drain_left", expq.size(), 0);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] held;
    int           acc_n;
    repeat (3) tick();
    rst_n = 1'b1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_do", DO, 0);
    check("rst_flags_q", flags_q, 0);
    check("rst_v_sticky", v_sticky, 0);

    // latency and one logic result
    out_ready = 1'b1;
    send(32'hf05af05a, 32'h0fa5f05a, 4'b0110, 0, 0, 0);
    check("lat_cycle1", out_valid, 0);
    tick();
    check("lat_cycle2", out_valid, 1);
    drain();
    check("xor_do", last_do, 32'hffff0000);
    check("xor_flags", last_f, 4'b0010);

    // logic sweep back to back
    for (int s = 0; s < 16; s++) send(32'hf05af05a, 32'h0fa5f05a, 4'(s), 0, 0, 0);
    drain();

    send(32'h01010000, 32'h10100101, 4'b1001, 1, 0, 0);
    drain();
    check("add_do", last_do, 32'h11110101);
    check("add_flags", last_f, 4'b0000);
    send(32'h0000ffff, 32'h00010000, 4'b0110, 1, 1, 0);
    drain();
    check("sub_do", last_do, 32'hffffffff);
    check("sub_flags", last_f, 4'b0010);

    send(32'h80000000, 32'h00000001, 4'b0110, 1, 1, 0);
    drain();
`ifdef ALU_SAT_EN
    check("ovf_do", last_do, 32'h80000000);
`else
    check("ovf_do", last_do, 32'h7fffffff);
`endif
    check("ovf_flags", last_f, 4'b1100);
    check("ovf_sticky", v_sticky, 1);

    send(32'hffffffff, 32'h00000001, 4'b1001, 1, 0, 0);
    send(32'h0, 32'h0, 4'b1001, 1, 0, 1);
    drain();
    check("chain1_do", prev_do, 32'h0);
    check("chain1_flags", prev_f, 4'b1001);
    check("chain2_do", last_do, 32'h1);
    check("chain2_c", last_f[3], 0);

    // backpressure: 3 ops offered while out_ready is held low
    out_ready = 1'b0;
    acc_n = 0;
    held = '0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      opA = 32'h100 * (acc_n + 1); opB = 32'h3; S = 4'b1001; M = 1'b1; Cin = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      if (cyc == 2) held = DO;
      if (cyc == 4) begin
        check("bp_do_held", DO, held);
        check("bp_in_ready", in_ready, 0);
      end
      if (in_ready) acc_n++;
      tick();
    end
    check("bp_accepted", acc_n, 2);
    out_ready = 1'b1;
    send(32'h300, 32'h3, 4'b1001, 1, 0, 0);
    drain();
    check("bp_last_do", last_do, 32'h303);

    // reset with two ops in flight
    out_ready = 1'b0;
    send(32'h80000000, 32'h1, 4'b1001, 1, 0, 0);
    send(32'h12345678, 32'h1, 4'b1001, 1, 0, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst2_out_valid", out_valid, 0);
    check("rst2_flags_q", flags_q, 0);
    check("rst2_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (3) tick();
    check("rst2_no_stale", out_valid, 0);

    // flag_clr while idle, then flag_clr coinciding with en2
    send(32'h80000000, 32'h1, 4'b0110, 1, 1, 0);
    drain();
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    model_c = 1'b0;
    model_sticky = 1'b0;
    check("clr_flags_q", flags_q, 0);
    check("clr_v_sticky", v_sticky, 0);
    send(32'h80000000, 32'h1, 4'b0110, 1, 1, 0);
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    check("clr_en2_flags_q", flags_q, 4'b1100);
    check("clr_en2_sticky", v_sticky, 1);
    drain();

    // randomized traffic
    for (int cyc = 0; cyc < 800; cyc++) begin
      case ($urandom_range(0, 4))
        0: opA = 32'h80000000;
        1: opA = 32'h7fffffff;
        2: opA = 32'hffffffff;
        default: opA = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: opB = 32'h0;
        1: opB = 32'h80000000;
        2: opB = 32'h1;
        default: opB = $urandom;
      endcase
      S = 4'($urandom_range(0, 15));
      M = 1'($urandom_range(0, 1));
      Cin = 1'($urandom_range(0, 1));
      cin_sel = 1'($urandom_range(0, 1));
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
